lift_car_position_model: RTL
============================

# lift_car_position_model

Cycle-accurate model of the lift car and shaft, sitting directly downstream of the main ALU block and closing the control loop. It consumes the ALU's motion/direction commands and the door state, moves the car floor-to-floor with a fixed travel time, and produces the one-hot floor sense vector that the ALU and request handler consume. It also flags illegal motion as a sticky fault.

## Interface
- N_FLOORS, default 8: number of floors; must be ≥ 2.
- TRAVEL_CYCLES, default 16: clock cycles spent between adjacent floors; must be ≥ 1.
- MIN_DWELL, default 2: minimum cycles the car stays aligned at a floor before it can depart; must be ≥ 1.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_motion  input  1  move command from the ALU; 1 = move.
- i_direction  input  1  direction command; 1 = up, 0 = down.
- i_door_open  input  1  door state; 1 = open.
- o_floor_sense  output  N_FLOORS  one-hot current floor when aligned; all zeros while between floors.
- o_floor_idx  output  $clog2(N_FLOORS)  binary index of the last floor reached.
- o_at_floor  output  1  car is aligned at a floor.
- o_fault  output  1  sticky fault; cleared only by reset.

## Operation
- The block has two states: AT_FLOOR and TRANSIT.
- Reset values:
  - state = AT_FLOOR, floor index = 0.
  - o_floor_sense = 1 (floor 0 only).
  - o_at_floor = 1, o_fault = 0.
  - Dwell counter = 0, so the car may depart immediately after reset.
- AT_FLOOR:
  - The dwell counter decrements each cycle and saturates at 0.
  - Departure requires all of: dwell counter = 0, i_motion = 1, i_door_open = 0, and the move is legal.
  - A legal move means not going up at floor N_FLOORS-1 and not going down at floor 0.
  - On departure: latch i_direction, load the travel counter with TRAVEL_CYCLES-1, enter TRANSIT.
  - An overtravel request (i_motion = 1 with an illegal direction and door closed) sets o_fault. The car does not move.
  - i_motion = 1 with the door open: no movement and no fault. The car waits.
- TRANSIT:
  - The travel counter decrements each cycle.
  - i_direction and i_motion are ignored. The car cannot reverse or stop between floors.
  - When the counter reaches 0: floor index ±1 per the latched direction, load the dwell counter with MIN_DWELL-1, return to AT_FLOOR.
  - i_door_open = 1 during any TRANSIT cycle sets o_fault. Travel still completes.
- Outputs are registered:
  - o_floor_sense = one-hot(floor index) when in AT_FLOOR, otherwise 0.
  - o_at_floor = 1 exactly when in AT_FLOOR.
- The floor index never leaves 0..N_FLOORS-1. No wrap-around is permitted.
- Reset asserted mid-TRANSIT returns the car to floor 0 immediately. This is a model reset, not physical behaviour.

## Timing
- Departure sampled at edge k: o_floor_sense and o_at_floor go to 0 at edge k.
- Arrival:
  - TRANSIT lasts exactly TRAVEL_CYCLES cycles.
  - o_floor_sense shows the new floor at edge k+TRAVEL_CYCLES.
- After arrival the car stays at the floor for at least MIN_DWELL cycles. This gives the ALU (one registered stage) time to observe o_floor_sense and drop i_motion before re-departure.
- If i_motion remains 1 throughout:
  - The car re-departs MIN_DWELL cycles after arrival.
  - Floor-to-floor period = TRAVEL_CYCLES + MIN_DWELL.
- o_fault rises on the edge that samples the faulting condition and then holds.
- o_floor_idx updates on the arrival edge and is stable during TRANSIT.

## Test plan
All scenarios use N_FLOORS=4, TRAVEL_CYCLES=4, MIN_DWELL=2.
- Reset, then i_motion=0 for 10 cycles → o_floor_sense=4'b0001, o_floor_idx=0, o_at_floor=1, o_fault=0 throughout.
- i_motion=1, i_direction=1, door closed at edge 0 → o_floor_sense=0 on edges 0–3; 4'b0010 at edge 4; held through edge 5; departs again at edge 6; 4'b0100 at edge 10.
- At floor 3, i_motion=1, i_direction=1 → no departure, o_floor_sense stays 4'b1000, o_fault=1 next edge and stays 1.
- Departure up from floor 1, then i_direction=0 and i_motion=0 on the next cycle → car still arrives at floor 2 after 4 cycles, o_floor_idx=2.
- Departure, then i_door_open=1 on the 2nd TRANSIT cycle → o_fault=1 on that edge; arrival still at cycle 4.
- At floor 0, i_motion=1 with i_door_open=1 for 5 cycles → no movement, o_fault=0; door closes → departs on that edge.
- Reset asserted mid-TRANSIT → o_floor_sense=4'b0001 and o_at_floor=1 asynchronously, o_fault=0.

Source files
------------

// File: rtl/lift_car_position_model_if.sv
// Bundles the ALU-facing command inputs and the car/shaft sense outputs.
// Pure wiring, no latency of its own.
// No flow control: commands are level-sensitive and sampled every clock.
interface lift_car_position_model_if #(
    parameter int N_FLOORS = 8
);
    localparam int IDX_W = $clog2(N_FLOORS);

    logic                i_motion;
    logic                i_direction;
    logic                i_door_open;
    logic [N_FLOORS-1:0] o_floor_sense;
    logic [IDX_W-1:0]    o_floor_idx;
    logic                o_at_floor;
    logic                o_fault;

    // Command source (ALU side)
    modport master (
        output i_motion, i_direction, i_door_open,
        input  o_floor_sense, o_floor_idx, o_at_floor, o_fault
    );

    // Car/shaft model side
    modport slave (
        input  i_motion, i_direction, i_door_open,
        output o_floor_sense, o_floor_idx, o_at_floor, o_fault
    );
endinterface

// File: rtl/lift_car_position_model.sv
// Lift car/shaft model: moves floor-to-floor on ALU commands, reports one-hot floor sense, sticky fault.
// Latency: outputs registered; departure seen same edge, arrival TRAVEL_CYCLES edges after departure.
// Backpressure: none; while the door is open or dwell is running, a move command simply waits.
module lift_car_position_model #(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int MIN_DWELL     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    lift_car_position_model_if.slave    bus
);
    localparam int IDX_W = $clog2(N_FLOORS);
    localparam int TW    = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW    = $clog2(MIN_DWELL + 1);

    localparam logic [IDX_W-1:0] TOP_FLOOR   = IDX_W'(N_FLOORS - 1);
    localparam logic [TW-1:0]    TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]    DWELL_LOAD  = DW'(MIN_DWELL - 1);

    typedef enum logic {
        AT_FLOOR = 1'b0,
        TRANSIT  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    floor_idx, floor_idx_nxt;
    logic                dir_q, dir_nxt;
    logic [DW-1:0]       dwell_cnt, dwell_nxt;
    logic [TW-1:0]       travel_cnt, travel_nxt;
    logic                fault_q, fault_nxt;
    logic [N_FLOORS-1:0] sense_q, sense_nxt;
    logic                at_floor_q;
    logic                move_legal;

    // Moving past the top or bottom landing is never legal.
    assign move_legal = bus.i_direction ? (floor_idx != TOP_FLOOR)
                                        : (floor_idx != '0);

    // State and registered outputs; reset parks the car at floor 0, doors ready, no fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= AT_FLOOR;
            floor_idx  <= '0;
            dir_q      <= 1'b0;
            dwell_cnt  <= '0;
            travel_cnt <= '0;
            fault_q    <= 1'b0;
            sense_q    <= N_FLOORS'(1);
            at_floor_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            floor_idx  <= floor_idx_nxt;
            dir_q      <= dir_nxt;
            dwell_cnt  <= dwell_nxt;
            travel_cnt <= travel_nxt;
            fault_q    <= fault_nxt;
            sense_q    <= sense_nxt;
            at_floor_q <= (state_nxt == AT_FLOOR);
        end
    end

    // Next-state: dwell/departure decisions at a floor, fixed-length travel between floors.
    always_comb begin
        state_nxt     = state;
        floor_idx_nxt = floor_idx;
        dir_nxt       = dir_q;
        dwell_nxt     = dwell_cnt;
        travel_nxt    = travel_cnt;
        fault_nxt     = fault_q;
        sense_nxt     = '0;

        case (state)
            AT_FLOOR: begin
                if (dwell_cnt != '0) begin
                    dwell_nxt = dwell_cnt - DW'(1);
                end
                // Door open: the request waits without moving or faulting.
                if (bus.i_motion && !bus.i_door_open) begin
                    if (!move_legal) begin
                        fault_nxt = 1'b1;
                    end else if (dwell_cnt == '0) begin
                        dir_nxt    = bus.i_direction;
                        travel_nxt = TRAVEL_LOAD;
                        state_nxt  = TRANSIT;
                    end
                end
            end
            TRANSIT: begin
                // Commands are ignored in the shaft; an open door is flagged but travel completes.
                if (bus.i_door_open) begin
                    fault_nxt = 1'b1;
                end
                if (travel_cnt == '0) begin
                    floor_idx_nxt = dir_q ? floor_idx + IDX_W'(1) : floor_idx - IDX_W'(1);
                    dwell_nxt     = DWELL_LOAD;
                    state_nxt     = AT_FLOOR;
                end else begin
                    travel_nxt = travel_cnt - TW'(1);
                end
            end
            default: begin
                state_nxt = AT_FLOOR;
            end
        endcase

        if (state_nxt == AT_FLOOR) begin
            sense_nxt[floor_idx_nxt] = 1'b1;
        end
    end

    assign bus.o_floor_sense = sense_q;
    assign bus.o_floor_idx   = floor_idx;
    assign bus.o_at_floor    = at_floor_q;
    assign bus.o_fault       = fault_q;
endmodule
